axis_trig_capture: RTL and testbench



---
 rtl/capture_pkg.sv | 11 +
 rtl/axis_capture_fifo.sv | 57 +++++
 rtl/axis_trig_capture.sv | 145 ++++++++++++++
 tb/tb_axis_trig_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// State encoding and width helper shared by the triggered ADC capture path.
package capture_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} cap_state_t;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_capture_fifo.sv
// Sync FIFO with a registered output stage; occupancy counts the output register too.
module axis_capture_fifo
    import capture_pkg::*;
#(
    parameter int W     = 17,
    parameter int DEPTH = 64
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    flush,
    input  logic                    wr,
    input  logic [W-1:0]            wr_data,
    input  logic                    drop_oldest,
    input  logic                    out_en,
    input  logic                    rd,
    output logic [W-1:0]            rd_data,
    output logic                    rd_valid,
    output logic [cnt_w(DEPTH)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] cnt;
    logic          load, take;

    // Refill the output register whenever it is empty or being popped; held while out_en is low.
    assign load      = out_en && (cnt != '0) && (!rd_valid || rd);
    assign take      = load || drop_oldest;
    assign occupancy = cnt + OW'(rd_valid);

    always_ff @(posedge aclk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge aclk) begin
        if (areset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr)   wr_ptr <= wr_ptr + 1'b1;
            if (take) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + OW'(wr) - OW'(take);
            if (load) begin
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
            end else if (rd) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_trig_capture.sv
// Threshold-triggered ADC snapshot: rolling pre-trigger history plus POST_LEN beats
// emitted to the DMA as one tlast-terminated packet.
module axis_trig_capture
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = 16,
    parameter int THRESHOLD    = 5000,
    parameter int PRE_TRIG     = 16,
    parameter int POST_LEN     = 1024,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] s_adc_tdata,
    input  logic                  s_adc_tvalid,
    output logic                  s_adc_tready,
    output logic [DATA_WIDTH-1:0] m_dma_tdata,
    output logic                  m_dma_tvalid,
    input  logic                  m_dma_tready,
    output logic                  m_dma_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int OW = cnt_w(FIFO_DEPTH);
    localparam int CW = cnt_w(POST_LEN);
    localparam logic [OW-1:0] OCC_PRE  = OW'(PRE_TRIG);
    localparam logic [OW-1:0] OCC_LIM  = OW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(POST_LEN - 1);
    localparam logic signed [SAMPLE_WIDTH-1:0] THR = SAMPLE_WIDTH'(THRESHOLD);

    cap_state_t                     state;
    logic [CW-1:0]                  post_cnt;
    logic [OW-1:0]                  occ, occ_eff;
    logic signed [SAMPLE_WIDTH-1:0] sample0;
    logic                           pop, trig, last_post, room;
    logic                           fifo_wr, fifo_drop, fifo_flush, wr_last, fifo_vld;
    logic [DATA_WIDTH:0]            fifo_q;

    assign s_adc_tready = 1'b1;
    assign sample0      = s_adc_tdata[SAMPLE_WIDTH-1:0];
    assign trig         = (state == ARMED) && s_adc_tvalid && (sample0 > THR) && (occ == OCC_PRE);
    assign pop          = fifo_vld && m_dma_tready;
    // A same-cycle DMA pop frees its slot before the room check.
    assign occ_eff      = occ - OW'(pop);
    assign last_post    = (post_cnt == CNT_LAST);
    assign room         = (occ_eff < OCC_LIM);

    always_comb begin
        fifo_wr    = 1'b0;
        fifo_drop  = 1'b0;
        fifo_flush = 1'b0;
        wr_last    = 1'b0;
        unique case (state)
            IDLE:    fifo_flush = arm;
            ARMED: begin
                if (abort) fifo_flush = 1'b1;
                else if (s_adc_tvalid) begin
                    fifo_wr = 1'b1;
                    if (trig) wr_last = (POST_LEN == 1);
                    else      fifo_drop = (occ == OCC_PRE);
                end
            end
            CAPTURE: begin
                if (abort) fifo_flush = 1'b1;
                else if (s_adc_tvalid) begin
                    // Last slot stays reserved so the tlast beat always lands.
                    wr_last = last_post;
                    fifo_wr = last_post || room;
                end
            end
            DRAIN:   fifo_flush = abort;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            post_cnt <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (arm) begin
                    state    <= ARMED;
                    overflow <= 1'b0;
                    post_cnt <= '0;
                end
                ARMED: begin
                    if (abort) state <= IDLE;
                    else if (trig) begin
                        post_cnt <= CW'(1);
                        state    <= (POST_LEN == 1) ? DRAIN : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (abort) state <= IDLE;
                    else if (s_adc_tvalid) begin
                        if (last_post) state <= DRAIN;
                        else begin
                            post_cnt <= post_cnt + 1'b1;
                            if (!room) overflow <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) state <= IDLE;
                    else if (pop && fifo_q[DATA_WIDTH]) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_capture_fifo #(
        .W     (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk        (aclk),
        .areset      (areset),
        .flush       (fifo_flush),
        .wr          (fifo_wr),
        .wr_data     ({wr_last, s_adc_tdata}),
        .drop_oldest (fifo_drop),
        .out_en      ((state == CAPTURE) || (state == DRAIN)),
        .rd          (pop),
        .rd_data     (fifo_q),
        .rd_valid    (fifo_vld),
        .occupancy   (occ)
    );

    assign m_dma_tdata  = fifo_q[DATA_WIDTH-1:0];
    assign m_dma_tvalid = fifo_vld;
    assign m_dma_tlast  = fifo_vld && fifo_q[DATA_WIDTH];
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_axis_trig_capture.sv
// Directed bench: trigger-pattern table plus overflow, abort and reset sequences.
// u_a: PRE_TRIG=4 POST_LEN=8 FIFO_DEPTH=16; u_b shares all inputs but has FIFO_DEPTH=8 so it overflows.
module tb_axis_trig_capture;
    localparam int DW = 16;

    logic          aclk = 1'b0;
    logic          areset, arm, abort, s_adc_tvalid, m_dma_tready;
    logic [DW-1:0] s_adc_tdata;
    logic          a_rdy, a_tv, a_tl, a_busy, a_done, a_ovf;
    logic          b_rdy, b_tv, b_tl, b_busy, b_done, b_ovf;
    logic [DW-1:0] a_td, b_td;

    always #5 aclk = ~aclk;

    axis_trig_capture #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(16), .THRESHOLD(5000),
                        .PRE_TRIG(4), .POST_LEN(8), .FIFO_DEPTH(16)) u_a (
        .aclk(aclk), .areset(areset), .arm(arm), .abort(abort),
        .s_adc_tdata(s_adc_tdata), .s_adc_tvalid(s_adc_tvalid), .s_adc_tready(a_rdy),
        .m_dma_tdata(a_td), .m_dma_tvalid(a_tv), .m_dma_tready(m_dma_tready),
        .m_dma_tlast(a_tl), .busy(a_busy), .done(a_done), .overflow(a_ovf));

    axis_trig_capture #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(16), .THRESHOLD(5000),
                        .PRE_TRIG(4), .POST_LEN(8), .FIFO_DEPTH(8)) u_b (
        .aclk(aclk), .areset(areset), .arm(arm), .abort(abort),
        .s_adc_tdata(s_adc_tdata), .s_adc_tvalid(s_adc_tvalid), .s_adc_tready(b_rdy),
        .m_dma_tdata(b_td), .m_dma_tvalid(b_tv), .m_dma_tready(m_dma_tready),
        .m_dma_tlast(b_tl), .busy(b_busy), .done(b_done), .overflow(b_ovf));

    typedef struct {
        string name;
        int    s1i, s1v, s2i, s2v;
        int    first;     // ramp index of first packet beat, -1 = no trigger expected
    } vec_t;

    int checks = 0, errors = 0;
    int s1i, s1v, s2i, s2v, rdy_lo_at, rdy_lo_len, abort_at, rst_at, arm_at, snap_at;
    int ga[$], gb[$];
    int la_n, lb_n, la_pos, lb_pos, tla_cyc, tlb_cyc, da_n, db_n, da_cyc, db_cyc;
    int sn_tv, sn_tl, sn_dn, sn_ov, sn_bz, sn_td;
    vec_t vecs[6];

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, want);
        end
    endtask

    // Ramp sample i, with up to two overridden indices.
    function automatic logic [DW-1:0] smp(input int i);
        int v;
        v = i;
        if (i == s1i) v = s1v;
        if (i == s2i) v = s2v;
        return DW'(v);
    endfunction

    task automatic set_defaults();
        s1i = -1; s1v = 0; s2i = -1; s2v = 0;
        rdy_lo_at = -1; rdy_lo_len = 0; abort_at = -1; rst_at = -1; arm_at = -1; snap_at = -1;
    endtask

    // Arm, then stream nbeats of ADC samples, recording DMA handshakes of both DUTs.
    task automatic stream(input int nbeats);
        ga.delete(); gb.delete();
        la_n = 0; lb_n = 0; la_pos = -1; lb_pos = -1; tla_cyc = -9; tlb_cyc = -9;
        da_n = 0; db_n = 0; da_cyc = -1; db_cyc = -1;
        @(posedge aclk); #1 arm = 1'b1;
        @(posedge aclk); #1 arm = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            s_adc_tvalid = 1'b1;
            s_adc_tdata  = smp(i);
            m_dma_tready = !(i >= rdy_lo_at && i < rdy_lo_at + rdy_lo_len);
            abort        = (i == abort_at);
            areset       = (i == rst_at);
            arm          = (i == arm_at);
            @(negedge aclk);
            if (a_tv && m_dma_tready) begin
                if (a_tl) begin la_n++; la_pos = ga.size(); tla_cyc = i; end
                ga.push_back(int'(a_td));
            end
            if (b_tv && m_dma_tready) begin
                if (b_tl) begin lb_n++; lb_pos = gb.size(); tlb_cyc = i; end
                gb.push_back(int'(b_td));
            end
            if (a_done) begin da_n++; da_cyc = i; end
            if (b_done) begin db_n++; db_cyc = i; end
            if (i == snap_at) begin
                sn_tv = a_tv; sn_tl = a_tl; sn_dn = a_done;
                sn_ov = a_ovf; sn_bz = a_busy; sn_td = int'(a_td);
            end
            @(posedge aclk); #1;
        end
        s_adc_tvalid = 1'b0; abort = 1'b0; areset = 1'b0; arm = 1'b0; m_dma_tready = 1'b1;
    endtask

    task automatic quiesce();
        @(posedge aclk); #1 abort = 1'b1;
        @(posedge aclk); #1 abort = 1'b0;
        @(posedge aclk); #1;
    endtask

    // Full 12-beat packet starting at ramp index first, tlast on beat 11, done one cycle later.
    task automatic check_pkt(input string nm, input bit sel, input int first);
        int n;
        n = sel ? gb.size() : ga.size();
        chk({nm, ".len"}, n, 12);
        for (int k = 0; k < 12 && k < n; k++)
            chk($sformatf("%s.dat%0d", nm, k), sel ? gb[k] : ga[k], int'(smp(first + k)));
        chk({nm, ".nlast"},    sel ? lb_n : la_n, 1);
        chk({nm, ".lastpos"},  sel ? lb_pos : la_pos, 11);
        chk({nm, ".done_n"},   sel ? db_n : da_n, 1);
        chk({nm, ".done_lat"}, sel ? db_cyc : da_cyc, (sel ? tlb_cyc : tla_cyc) + 1);
    endtask

    initial begin
        int bidx[8];
        areset = 1'b1; arm = 1'b0; abort = 1'b0; s_adc_tvalid = 1'b0;
        s_adc_tdata = '0; m_dma_tready = 1'b1;
        set_defaults();

        vecs[0] = '{"ramp20",   20, 6000, -1,     0, 16};
        vecs[1] = '{"early",     1, 6000, 10,  6000,  6};
        vecs[2] = '{"eq5000",    5, 5000, 12,  5001,  8};
        vecs[3] = '{"neg6000",   5, -6000, 14, 6000, 10};
        vecs[4] = '{"fillhist",  3, 6000,  4,  7000,  0};
        vecs[5] = '{"notrig",    5, 5000,  9, -6000, -1};

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst.tvalid", int'(a_tv), 0);
        chk("rst.tlast", int'(a_tl), 0);
        chk("rst.done", int'(a_done), 0);
        chk("rst.overflow", int'(a_ovf), 0);
        chk("rst.busy", int'(a_busy), 0);
        chk("rst.tdata", int'(a_td), 0);
        chk("rst.adc_tready", int'(a_rdy), 1);
        chk("rst.b_tvalid", int'(b_tv), 0);
        @(posedge aclk); #1 areset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            set_defaults();
            s1i = vecs[v].s1i; s1v = vecs[v].s1v; s2i = vecs[v].s2i; s2v = vecs[v].s2v;
            stream(45);
            if (vecs[v].first >= 0) begin
                check_pkt({vecs[v].name, ".a"}, 1'b0, vecs[v].first);
                check_pkt({vecs[v].name, ".b"}, 1'b1, vecs[v].first);
                chk({vecs[v].name, ".ovf"}, int'(a_ovf), 0);
                chk({vecs[v].name, ".busy"}, int'(a_busy), 0);
            end else begin
                chk({vecs[v].name, ".len"}, ga.size(), 0);
                chk({vecs[v].name, ".done_n"}, da_n, 0);
                chk({vecs[v].name, ".busy"}, int'(a_busy), 1);
            end
            quiesce();
        end

        // DMA stalled 20 cycles from the trigger: u_b keeps post beats 0..2 and the tlast beat.
        set_defaults();
        s1i = 20; s1v = 6000; rdy_lo_at = 20; rdy_lo_len = 20;
        stream(70);
        check_pkt("stall.a", 1'b0, 16);
        chk("stall.a_ovf", int'(a_ovf), 0);
        bidx = '{16, 17, 18, 19, 20, 21, 22, 27};
        chk("stall.b_len", gb.size(), 8);
        for (int k = 0; k < 8 && k < gb.size(); k++)
            chk($sformatf("stall.b_dat%0d", k), gb[k], int'(smp(bidx[k])));
        chk("stall.b_nlast", lb_n, 1);
        chk("stall.b_lastpos", lb_pos, 7);
        chk("stall.b_done_n", db_n, 1);
        chk("stall.b_done_lat", db_cyc, tlb_cyc + 1);
        chk("stall.b_ovf", int'(b_ovf), 1);
        quiesce();

        // Abort three beats into CAPTURE: two history beats already out, then nothing.
        set_defaults();
        s1i = 20; s1v = 6000; abort_at = 23; snap_at = 24;
        stream(40);
        chk("abort.len", ga.size(), 2);
        chk("abort.nlast", la_n, 0);
        chk("abort.done_n", da_n, 0);
        chk("abort.tvalid_next", sn_tv, 0);
        chk("abort.busy_next", sn_bz, 0);
        chk("abort.b_ovf_cleared", int'(b_ovf), 0);
        quiesce();

        set_defaults();
        s1i = 20; s1v = 6000;
        stream(45);
        check_pkt("rearm.a", 1'b0, 16);
        chk("rearm.a_ovf", int'(a_ovf), 0);
        chk("rearm.b_ovf", int'(b_ovf), 0);
        quiesce();

        // Reset while draining; an arm pulse mid-capture must not disturb the packet.
        set_defaults();
        s1i = 20; s1v = 6000; arm_at = 22; rst_at = 29; snap_at = 30;
        stream(40);
        chk("rstdrain.len", ga.size(), 8);
        for (int k = 0; k < 8 && k < ga.size(); k++)
            chk($sformatf("rstdrain.dat%0d", k), ga[k], int'(smp(16 + k)));
        chk("rstdrain.nlast", la_n, 0);
        chk("rstdrain.done_n", da_n, 0);
        chk("rstdrain.tvalid", sn_tv, 0);
        chk("rstdrain.tlast", sn_tl, 0);
        chk("rstdrain.done", sn_dn, 0);
        chk("rstdrain.overflow", sn_ov, 0);
        chk("rstdrain.busy", sn_bz, 0);
        chk("rstdrain.tdata", sn_td, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
